// File: rtl/cache_pkg.sv
// Shared types for the data cache and its memory-side line controller.
package cache_pkg;

    localparam int N_ELEMENTS = 4;
    localparam int N_BYTES    = 4;
    localparam int LINE_WIDTH = N_ELEMENTS * N_BYTES * 8;
    localparam int PA_WIDTH   = 32;
    localparam int ID_WIDTH   = 4;

    typedef enum logic {
        MEM_LOAD  = 1'b0,
        MEM_STORE = 1'b1
    } mem_type_t;

    typedef struct packed {
        logic [PA_WIDTH-1:0]   addr;
        logic [LINE_WIDTH-1:0] data;
        mem_type_t             req_type;
        logic [ID_WIDTH-1:0]   id;
    } mem_req_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } mem_ctrl_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, power-of-2 depth, comb read of the head entry.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    // Full/empty come from registered count only, so a pop never frees a slot for a same-cycle push.
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/mem_line_ctrl.sv
// Memory-side line controller: queues tagged line requests, serves them in order against a
// line-wide backing store. Build option MEM_LINE_CTRL_STORE_ACK_EN makes stores respond too.
//
// state | meaning
// IDLE  | waiting for a queued request; pops the FIFO head when one exists
// BUSY  | access latency countdown on the working request
// RESP  | response held on o_resp_* until i_resp_ack
module mem_line_ctrl
    import cache_pkg::*;
#(
    parameter int N_ELEMENTS  = cache_pkg::N_ELEMENTS,
    parameter int N_BYTES     = cache_pkg::N_BYTES,
    parameter int PA_WIDTH    = cache_pkg::PA_WIDTH,
    parameter int ID_WIDTH    = cache_pkg::ID_WIDTH,
    parameter int QUEUE_DEPTH = 4,
    parameter int MEM_LINES   = 64,
    parameter int LATENCY     = 5,
    parameter int LINE_WIDTH  = N_ELEMENTS * N_BYTES * 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req_enable,
    input  logic [PA_WIDTH-1:0]   i_req_addr,
    input  logic [LINE_WIDTH-1:0] i_req_data,
    input  logic                  i_req_type,
    input  logic                  i_resp_ack,
    output logic                  o_req_ready,
    output logic [ID_WIDTH-1:0]   o_req_id,
    output logic                  o_resp_enable,
    output logic [LINE_WIDTH-1:0] o_resp_data,
    output logic [ID_WIDTH-1:0]   o_resp_id
);

    localparam int OFF   = $clog2(N_ELEMENTS * N_BYTES);
    localparam int IDX_W = $clog2(MEM_LINES);
    localparam int CNT_W = $clog2(LATENCY) + 1;

    mem_ctrl_state_t       state, state_nxt;
    mem_req_t              work;
    mem_req_t              push_entry;
    mem_req_t              fifo_head;
    logic [CNT_W-1:0]      cnt;
    logic [LINE_WIDTH-1:0] mem [MEM_LINES];
    logic [IDX_W-1:0]      work_idx;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic                  done;
    logic                  resp_load;
    logic                  mem_we;
    logic                  unused_addr_bits;

    assign push       = i_req_enable && !fifo_full;
    assign o_req_ready = !fifo_full;
    assign push_entry = '{addr: i_req_addr, data: i_req_data,
                          req_type: mem_type_t'(i_req_type), id: o_req_id};
    assign work_idx   = work.addr[OFF +: IDX_W];
    assign unused_addr_bits = ^work.addr;

    sync_fifo #(
        .WIDTH ($bits(mem_req_t)),
        .DEPTH (QUEUE_DEPTH)
    ) u_req_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (!fifo_empty) state_nxt = BUSY;
            BUSY: if (cnt == '0) state_nxt = resp_load ? RESP : IDLE;
            RESP: if (i_resp_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pop       = (state == IDLE) && !fifo_empty;
        done      = (state == BUSY) && (cnt == '0);
`ifdef MEM_LINE_CTRL_STORE_ACK_EN
        resp_load = done;
`else
        resp_load = done && (work.req_type == MEM_LOAD);
`endif
        mem_we    = done && (work.req_type == MEM_STORE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            work          <= '0;
            cnt           <= '0;
            o_req_id      <= '0;
            o_resp_enable <= 1'b0;
            o_resp_data   <= '0;
            o_resp_id     <= '0;
        end else begin
            if (push) begin
                o_req_id <= o_req_id + 1'b1;
            end
            if (pop) begin
                work <= fifo_head;
                cnt  <= CNT_W'(LATENCY - 1);
            end else if (state == BUSY && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (resp_load) begin
                o_resp_enable <= 1'b1;
                o_resp_data   <= (work.req_type == MEM_STORE) ? work.data : mem[work_idx];
                o_resp_id     <= work.id;
            end else if (state == RESP && i_resp_ack) begin
                o_resp_enable <= 1'b0;
            end
        end
    end

    // Gated by rst so a store caught mid-flight by reset never reaches the array.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem[work_idx] <= work.data;
        end
    end

endmodule
